// File: rtl/player_input_pkg.sv
// Shared types for the player motion controller:
// jump FSM states and arbitrated horizontal direction.
package player_input_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } jump_state_t;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_RIGHT = 2'b10
  } dir_t;

  localparam int VY_W_DEF     = 8;
  localparam int JUMP_V_DEF   = 12;
  localparam int GRAVITY_DEF  = 1;
  localparam int MAX_FALL_DEF = 8;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw button plus a
// registered one-cycle rising-edge pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_last;
  logic r_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_last <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_meta <= raw;
      r_sync <= r_meta;
      r_last <= r_sync;
      r_rise <= r_sync & ~r_last;
    end
  end

  assign level = r_sync;
  assign rise  = r_rise;

endmodule

// File: rtl/player_input_ctrl.sv
// Per-frame player controller: button sync, left/right
// arbitration, jump/gravity FSM and registered updates.
module player_input_ctrl
  import player_input_pkg::*;
#(
  parameter int VY_W     = VY_W_DEF,
  parameter int JUMP_V   = JUMP_V_DEF,
  parameter int GRAVITY  = GRAVITY_DEF,
  parameter int MAX_FALL = MAX_FALL_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            frame_tick,
  input  logic            btn_left,
  input  logic            btn_right,
  input  logic            btn_jump,
  input  logic            on_ground,
  input  logic            hit_ceiling,
  output logic [1:0]      move_dir,
  output logic [VY_W-1:0] vy,
  output logic            airborne,
  output logic            upd_valid
);

  localparam logic signed [VY_W:0] LP_GRAV =
    (VY_W+1)'(GRAVITY);
  localparam logic signed [VY_W:0] LP_MAXF =
    (VY_W+1)'(MAX_FALL);
  localparam logic [VY_W-1:0] LP_VY_JUMP =
    VY_W'(-JUMP_V);

  logic w_l_lvl, w_l_rise;
  logic w_r_lvl, w_r_rise;
  logic w_j_lvl, w_j_rise;

  btn_sync_edge u_left (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_left),
    .level (w_l_lvl),
    .rise  (w_l_rise)
  );

  btn_sync_edge u_right (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_right),
    .level (w_r_lvl),
    .rise  (w_r_rise)
  );

  btn_sync_edge u_jump (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_jump),
    .level (w_j_lvl),
    .rise  (w_j_rise)
  );

  dir_t            r_last_dir;
  dir_t            w_dir_nxt;
  dir_t            r_move_dir;
  jump_state_t     r_state;
  logic [VY_W-1:0] r_vy;
  logic            r_airborne;
  logic            r_upd_valid;
  logic            r_jump_req;

  logic signed [VY_W:0] w_vy_inc;
  logic [VY_W-1:0]      w_vy_fall;

  // Last-pressed-wins; left takes simultaneous presses.
  always_comb begin
    w_dir_nxt = r_last_dir;
    if (w_l_rise)
      w_dir_nxt = DIR_LEFT;
    else if (w_r_rise)
      w_dir_nxt = DIR_RIGHT;
    else if (!w_l_lvl && !w_r_lvl)
      w_dir_nxt = DIR_NONE;
    else if (r_last_dir == DIR_LEFT && !w_l_lvl)
      w_dir_nxt = DIR_RIGHT;
    else if (r_last_dir == DIR_RIGHT && !w_r_lvl)
      w_dir_nxt = DIR_LEFT;
  end

  always_comb begin
    w_vy_inc  = $signed({r_vy[VY_W-1], r_vy}) + LP_GRAV;
    w_vy_fall = w_vy_inc[VY_W-1:0];
    if (w_vy_inc > LP_MAXF)
      w_vy_fall = LP_MAXF[VY_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_dir  <= DIR_NONE;
      r_move_dir  <= DIR_NONE;
      r_state     <= GROUND;
      r_vy        <= '0;
      r_airborne  <= 1'b0;
      r_upd_valid <= 1'b0;
      r_jump_req  <= 1'b0;
    end else begin
      r_upd_valid <= 1'b0;
      r_last_dir  <= w_dir_nxt;
      // A press landing on the tick itself waits for the next one.
      if (frame_tick)
        r_jump_req <= w_j_rise;
      else if (w_j_rise)
        r_jump_req <= 1'b1;
      if (frame_tick) begin
        r_upd_valid <= 1'b1;
        r_move_dir  <= r_last_dir;
        unique case (r_state)
          GROUND: begin
            if (!on_ground) begin
              r_state    <= FALL;
              r_vy       <= LP_GRAV[VY_W-1:0];
              r_airborne <= 1'b1;
            end else if (r_jump_req) begin
              r_state    <= RISE;
              r_vy       <= LP_VY_JUMP;
              r_airborne <= 1'b1;
            end else begin
              r_vy       <= '0;
              r_airborne <= 1'b0;
            end
          end
          RISE: begin
            r_airborne <= 1'b1;
            if (hit_ceiling || !w_j_lvl) begin
              r_state <= FALL;
              r_vy    <= '0;
            end else if (!w_vy_inc[VY_W]) begin
              r_state <= FALL;
              r_vy    <= '0;
            end else begin
              r_vy <= w_vy_inc[VY_W-1:0];
            end
          end
          FALL: begin
            if (on_ground) begin
              r_state    <= GROUND;
              r_vy       <= '0;
              r_airborne <= 1'b0;
            end else begin
              r_vy       <= w_vy_fall;
              r_airborne <= 1'b1;
            end
          end
          default: begin
            r_state    <= GROUND;
            r_vy       <= '0;
            r_airborne <= 1'b0;
          end
        endcase
      end
    end
  end

  assign move_dir  = r_move_dir;
  assign vy        = r_vy;
  assign airborne  = r_airborne;
  assign upd_valid = r_upd_valid;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed bench for player_input_ctrl with a queue of
// expected frame updates checked on each upd_valid.
module tb_player_input_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       btn_left, btn_right, btn_jump;
  logic       on_ground, hit_ceiling;
  logic [1:0] move_dir;
  logic [7:0] vy;
  logic       airborne;
  logic       upd_valid;

  typedef struct packed {
    logic [1:0] d;
    logic [7:0] v;
    logic       a;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  player_input_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_jump    (btn_jump),
    .on_ground   (on_ground),
    .hit_ceiling (hit_ceiling),
    .move_dir    (move_dir),
    .vy          (vy),
    .airborne    (airborne),
    .upd_valid   (upd_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, $signed(obs), $signed(exp));
    end
  endtask

  always @(negedge clk) begin
    if (upd_valid === 1'b1) begin
      exp_t e;
      n_assert++;
      assert (q.size() > 0) else begin
        n_fail++;
        $error("FAIL upd_extra: observed 1 expected 0");
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        check("move_dir", {6'b0, move_dir}, {6'b0, e.d});
        check("vy", vy, e.v);
        check("airborne", {7'b0, airborne}, {7'b0, e.a});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic [1:0] d,
                      input int v,
                      input logic a);
    q.push_back('{d, 8'(v), a});
    @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    cyc(2);
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_dir"}, {6'b0, move_dir}, 8'd0);
    check({tag, "_vy"}, vy, 8'd0);
    check({tag, "_air"}, {7'b0, airborne}, 8'd0);
    check({tag, "_upd"}, {7'b0, upd_valid}, 8'd0);
  endtask

  initial begin
    reset = 1'b0;
    frame_tick = 1'b0;
    btn_left = 1'b0;
    btn_right = 1'b0;
    btn_jump = 1'b0;
    on_ground = 1'b1;
    hit_ceiling = 1'b0;

    for (int i = 0; i < 8; i++) begin
      logic [2:0] p;
      p = 3'(i);
      cyc(1);
      btn_left = p[0];
      btn_jump = p[1];
      btn_right = p[2];
      frame_tick = p[0];
      cyc(1);
      chk_idle("rst");
    end
    btn_left = 1'b0;
    btn_right = 1'b0;
    btn_jump = 1'b0;
    frame_tick = 1'b0;
    cyc(4);
    reset = 1'b1;
    cyc(6);
    tick(2'b00, 0, 1'b0);

    btn_jump = 1'b1;
    cyc(6);
    tick(2'b00, -12, 1'b1);
    for (int k = 2; k <= 12; k++)
      tick(2'b00, k - 13, 1'b1);
    tick(2'b00, 0, 1'b1);
    btn_jump = 1'b0;
    on_ground = 1'b0;
    cyc(6);
    for (int k = 1; k <= 8; k++)
      tick(2'b00, k, 1'b1);
    tick(2'b00, 8, 1'b1);
    tick(2'b00, 8, 1'b1);
    on_ground = 1'b1;
    tick(2'b00, 0, 1'b0);

    btn_jump = 1'b1;
    cyc(6);
    tick(2'b00, -12, 1'b1);
    tick(2'b00, -11, 1'b1);
    tick(2'b00, -10, 1'b1);
    btn_jump = 1'b0;
    cyc(6);
    tick(2'b00, 0, 1'b1);
    tick(2'b00, 0, 1'b0);

    btn_jump = 1'b1;
    cyc(6);
    tick(2'b00, -12, 1'b1);
    tick(2'b00, -11, 1'b1);
    hit_ceiling = 1'b1;
    tick(2'b00, 0, 1'b1);
    hit_ceiling = 1'b0;
    tick(2'b00, 0, 1'b0);
    btn_jump = 1'b0;
    cyc(6);

    btn_right = 1'b1;
    cyc(6);
    tick(2'b10, 0, 1'b0);
    btn_left = 1'b1;
    cyc(6);
    tick(2'b01, 0, 1'b0);
    btn_left = 1'b0;
    cyc(6);
    tick(2'b10, 0, 1'b0);
    btn_right = 1'b0;
    cyc(6);
    btn_left = 1'b1;
    btn_right = 1'b1;
    cyc(6);
    tick(2'b01, 0, 1'b0);
    btn_left = 1'b0;
    btn_right = 1'b0;
    cyc(6);
    tick(2'b00, 0, 1'b0);

    q.push_back('{2'b00, 8'd0, 1'b0});
    @(posedge clk);
    #1 btn_jump = 1'b1;
    repeat (3) @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    cyc(2);
    tick(2'b00, -12, 1'b1);
    btn_jump = 1'b0;
    cyc(6);
    tick(2'b00, 0, 1'b1);
    tick(2'b00, 0, 1'b0);

    on_ground = 1'b0;
    tick(2'b00, 1, 1'b1);
    btn_jump = 1'b1;
    cyc(6);
    tick(2'b00, 2, 1'b1);
    on_ground = 1'b1;
    tick(2'b00, 0, 1'b0);
    tick(2'b00, 0, 1'b0);
    btn_jump = 1'b0;
    cyc(6);

    on_ground = 1'b0;
    tick(2'b00, 1, 1'b1);
    tick(2'b00, 2, 1'b1);
    btn_jump = 1'b1;
    cyc(6);
    reset = 1'b0;
    #2;
    chk_idle("rst_air");
    btn_jump = 1'b0;
    on_ground = 1'b1;
    cyc(4);
    reset = 1'b1;
    cyc(6);
    tick(2'b00, 0, 1'b0);

    cyc(5);
    n_assert++;
    assert (q.size() == 0) else begin
      n_fail++;
      $error("FAIL upd_missing: observed %0d expected 0",
             q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
